lvda_tlm_tag_bank: RTL and testbench

- Parametrised successor to the fixed LVDA tag/real-time telemetry register group.
- Holds NUM_REGS telemetry registers of WIDTH bits each.
- Registers are loaded and cleared by phase-qualified processor strobes.
- A selected register is snapshotted and shifted out MSB-first to the telemetry multiplexer under a bit-time strobe, with busy/valid/done handshake.

---
 rtl/lvda_tlm_pkg.sv | 30 +++
 rtl/lvda_tlm_serializer.sv | 116 +++++++++++
 rtl/lvda_tlm_tag_bank.sv | 102 ++++++++++
 tb/tb_lvda_tlm_tag_bank.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvda_tlm_pkg.sv
// Shared definitions for the LVDA telemetry tag bank.
//   - tlm_state_e  : serialiser FSM states (IDLE, LOAD, SHIFT, DONE)
//   - default WIDTH / NUM_REGS localparams
//   - odd_parity   : odd-parity bit over a word (XOR of the bits, inverted)
//   - sel_in_range : select-index range check against a slot count
// odd_parity is only referenced when LVDA_TLM_PARITY_EN is defined.
package lvda_tlm_pkg;

   localparam int LVDA_TLM_DEF_WIDTH    = 8;
   localparam int LVDA_TLM_DEF_NUM_REGS = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } tlm_state_e;

   // Callers zero-extend the word to 32 bits; the extra zeros leave the XOR unchanged.
   function automatic logic odd_parity(input logic [31:0] data);
      return ~(^data);
   endfunction

   // The comparison is done at 32 bits so it stays meaningful even when
   // SEL_W spans exactly NUM_REGS values.
   function automatic logic sel_in_range(input logic [31:0] sel, input int unsigned n);
      return sel < n;
   endfunction

endpackage

// File: rtl/lvda_tlm_serializer.sv
// Snapshot-and-shift serialiser for one telemetry register.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   req         : accepted request (caller has already range-checked req_sel)
//   req_sel     : slot to snapshot
//   bit_stb     : one-cycle bit-time strobe
//   reg_q       : live register bank, slot i at [i*WIDTH +: WIDTH]
//   busy        : high from the LOAD cycle through the DONE cycle
//   tlm_bit     : last shifted bit, held between strobes
//   bit_vld     : one-cycle pulse, tlm_bit is new
//   done        : one-cycle pulse, one cycle after the last bit_vld
// Macro LVDA_TLM_PARITY_EN appends an odd-parity bit after the data bits.
module lvda_tlm_serializer
   import lvda_tlm_pkg::*;
#(
   parameter int NUM_REGS = LVDA_TLM_DEF_NUM_REGS,
   parameter int WIDTH    = LVDA_TLM_DEF_WIDTH,
   parameter int SEL_W    = $clog2(NUM_REGS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req,
   input  logic [SEL_W-1:0]          req_sel,
   input  logic                      bit_stb,
   input  logic [NUM_REGS*WIDTH-1:0] reg_q,
   output logic                      busy,
   output logic                      tlm_bit,
   output logic                      bit_vld,
   output logic                      done
);

`ifdef LVDA_TLM_PARITY_EN
   localparam int NBITS = WIDTH + 1;
`else
   localparam int NBITS = WIDTH;
`endif
   localparam int CNT_W  = $clog2(NBITS + 1);
   localparam int STAGES = 1;

   tlm_state_e        state, state_nxt;
   logic [SEL_W-1:0]  sel_q;
   logic [WIDTH-1:0]  src_word;
   logic [NBITS-1:0]  load_word;
   logic [NBITS-1:0]  shreg;
   logic [CNT_W-1:0]  bitcnt;
   logic              last_q;   // final bit shifted; hold SHIFT one more cycle so DONE trails its VLD
   logic              bit_q;
   logic [STAGES:0]   vld_pipe;
   logic              shift_en;

   // Strobes in LOAD or in the drain cycle after the last bit are not taken.
   assign shift_en    = (state == ST_SHIFT) && !last_q && bit_stb;
   assign vld_pipe[0] = shift_en;

   always_comb begin
      src_word = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (sel_q == SEL_W'(i)) src_word = reg_q[i*WIDTH +: WIDTH];
      end
   end

`ifdef LVDA_TLM_PARITY_EN
   assign load_word = {src_word, odd_parity(32'(src_word))};
`else
   assign load_word = src_word;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (req) state_nxt = ST_LOAD;
         ST_LOAD:  state_nxt = ST_SHIFT;
         ST_SHIFT: if (last_q) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q              <= '0;
         shreg              <= '0;
         bitcnt             <= '0;
         last_q             <= 1'b0;
         bit_q              <= 1'b0;
         vld_pipe[STAGES:1] <= '0;
      end else begin
         vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
         if (state == ST_IDLE && req) sel_q <= req_sel;
         if (state == ST_LOAD) begin
            // The bank already holds writes committed on the request edge.
            shreg  <= load_word;
            bitcnt <= CNT_W'(NBITS - 1);
            last_q <= 1'b0;
         end else if (shift_en) begin
            bit_q <= shreg[NBITS-1];
            shreg <= shreg << 1;
            if (bitcnt == '0) last_q <= 1'b1;
            else              bitcnt <= bitcnt - 1'b1;
         end else if (state == ST_DONE) begin
            last_q <= 1'b0;
         end
      end
   end

   assign busy    = (state != ST_IDLE);
   assign done    = (state == ST_DONE);
   assign tlm_bit = bit_q;
   assign bit_vld = vld_pipe[STAGES];

endmodule

// File: rtl/lvda_tlm_tag_bank.sv
// LVDA tag / real-time telemetry register bank.
// NUM_REGS registers of WIDTH bits, loaded and cleared by PHASE-qualified
// strobes; one selected register is serialised MSB-first on request.
// Ports:
//   SIM_CLK, SIM_RSTN          : clock, asynchronous active-low reset
//   PHASE                      : qualifies WR_STB / CLR_STB / CLR_ALL
//   WR_STB, WR_SEL, WR_DATA    : register load
//   CLR_STB, CLR_SEL, CLR_ALL  : single / global clear (load wins on a collision)
//   TLM_REQ, TLM_SEL, BIT_STB  : serialise request and bit-time strobe
//   REG_Q                      : live registers, slot i at [i*WIDTH +: WIDTH]
//   WR_ERR                     : one pulse the cycle after any out-of-range select
//   TLM_BUSY, TLM_BIT, TLM_BIT_VLD, TLM_DONE : serialiser handshake
// Macro LVDA_TLM_PARITY_EN adds a trailing odd-parity bit to each transfer.
module lvda_tlm_tag_bank
   import lvda_tlm_pkg::*;
#(
   parameter int NUM_REGS = LVDA_TLM_DEF_NUM_REGS,
   parameter int WIDTH    = LVDA_TLM_DEF_WIDTH,
   parameter int SEL_W    = $clog2(NUM_REGS)
) (
   input  logic                      SIM_CLK,
   input  logic                      SIM_RSTN,
   input  logic                      PHASE,
   input  logic                      WR_STB,
   input  logic [SEL_W-1:0]          WR_SEL,
   input  logic [WIDTH-1:0]          WR_DATA,
   input  logic                      CLR_STB,
   input  logic [SEL_W-1:0]          CLR_SEL,
   input  logic                      CLR_ALL,
   input  logic                      TLM_REQ,
   input  logic [SEL_W-1:0]          TLM_SEL,
   input  logic                      BIT_STB,
   output logic [NUM_REGS*WIDTH-1:0] REG_Q,
   output logic                      WR_ERR,
   output logic                      TLM_BUSY,
   output logic                      TLM_BIT,
   output logic                      TLM_BIT_VLD,
   output logic                      TLM_DONE
);

   logic wr_inr, clr_inr, tlm_inr;
   logic wr_go, clr_go, clr_all_go, tlm_go;
   logic err_d, err_q;
   logic [NUM_REGS-1:0][WIDTH-1:0] regs;

   assign wr_inr  = sel_in_range(32'(WR_SEL),  NUM_REGS);
   assign clr_inr = sel_in_range(32'(CLR_SEL), NUM_REGS);
   assign tlm_inr = sel_in_range(32'(TLM_SEL), NUM_REGS);

   assign wr_go      = PHASE & WR_STB  & wr_inr;
   assign clr_go     = PHASE & CLR_STB & clr_inr;
   assign clr_all_go = PHASE & CLR_ALL;
   // Requests are not phase-gated; the serialiser ignores them while busy.
   assign tlm_go     = TLM_REQ & tlm_inr;

   // Requests seen while busy are dropped silently, so they never flag an error.
   assign err_d = (PHASE & WR_STB  & ~wr_inr)
                | (PHASE & CLR_STB & ~clr_inr)
                | (TLM_REQ & ~TLM_BUSY & ~tlm_inr);

   always_ff @(posedge SIM_CLK or negedge SIM_RSTN) begin
      if (!SIM_RSTN) err_q <= 1'b0;
      else           err_q <= err_d;
   end

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_slot
      logic [WIDTH-1:0] slot_q;
      logic             hit_wr, hit_clr;

      assign hit_wr  = wr_go && (WR_SEL == SEL_W'(i));
      assign hit_clr = clr_all_go || (clr_go && (CLR_SEL == SEL_W'(i)));

      always_ff @(posedge SIM_CLK or negedge SIM_RSTN) begin
         if (!SIM_RSTN)    slot_q <= '0;
         else if (hit_wr)  slot_q <= WR_DATA;
         else if (hit_clr) slot_q <= '0;
      end

      assign regs[i] = slot_q;
   end

   assign REG_Q  = regs;
   assign WR_ERR = err_q;

   lvda_tlm_serializer #(
      .NUM_REGS (NUM_REGS),
      .WIDTH    (WIDTH),
      .SEL_W    (SEL_W)
   ) u_ser (
      .clk     (SIM_CLK),
      .rst_n   (SIM_RSTN),
      .req     (tlm_go),
      .req_sel (TLM_SEL),
      .bit_stb (BIT_STB),
      .reg_q   (REG_Q),
      .busy    (TLM_BUSY),
      .tlm_bit (TLM_BIT),
      .bit_vld (TLM_BIT_VLD),
      .done    (TLM_DONE)
   );

endmodule

// File: tb/tb_lvda_tlm_tag_bank.sv
// Scoreboard bench for lvda_tlm_tag_bank (NUM_REGS=6, WIDTH=8).
// A transfer-level reference model runs on the rising edge and queues
// cycle-stamped expected events; a monitor on the falling edge pops and
// compares them whenever the DUT pulses TLM_BIT_VLD, TLM_DONE or WR_ERR.
module tb_lvda_tlm_tag_bank;

   localparam int NR = 6;
   localparam int W  = 8;
   localparam int SW = 3;
`ifdef LVDA_TLM_PARITY_EN
   localparam int NB = W + 1;
   localparam bit PAR = 1'b1;
`else
   localparam int NB = W;
   localparam bit PAR = 1'b0;
`endif

   logic          SIM_CLK = 1'b0;
   logic          SIM_RSTN = 1'b0;
   logic          PHASE = 1'b0;
   logic          WR_STB = 1'b0;
   logic [SW-1:0] WR_SEL = '0;
   logic [W-1:0]  WR_DATA = '0;
   logic          CLR_STB = 1'b0;
   logic [SW-1:0] CLR_SEL = '0;
   logic          CLR_ALL = 1'b0;
   logic          TLM_REQ = 1'b0;
   logic [SW-1:0] TLM_SEL = '0;
   logic          BIT_STB = 1'b0;
   logic [NR*W-1:0] REG_Q;
   logic          WR_ERR, TLM_BUSY, TLM_BIT, TLM_BIT_VLD, TLM_DONE;

   always #5 SIM_CLK = ~SIM_CLK;

   lvda_tlm_tag_bank #(.NUM_REGS(NR), .WIDTH(W), .SEL_W(SW)) dut (
      .SIM_CLK(SIM_CLK), .SIM_RSTN(SIM_RSTN), .PHASE(PHASE),
      .WR_STB(WR_STB), .WR_SEL(WR_SEL), .WR_DATA(WR_DATA),
      .CLR_STB(CLR_STB), .CLR_SEL(CLR_SEL), .CLR_ALL(CLR_ALL),
      .TLM_REQ(TLM_REQ), .TLM_SEL(TLM_SEL), .BIT_STB(BIT_STB),
      .REG_Q(REG_Q), .WR_ERR(WR_ERR), .TLM_BUSY(TLM_BUSY),
      .TLM_BIT(TLM_BIT), .TLM_BIT_VLD(TLM_BIT_VLD), .TLM_DONE(TLM_DONE)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { int stamp; logic b; } bit_ev_t;

   logic [W-1:0] m_regs [NR];
   bit_ev_t      bit_q[$];
   int           done_q[$];
   int           err_q[$];
   logic         m_bits[$];     // bits of the active transfer still to go out
   bit           m_act = 1'b0;
   int           m_load_cyc = 0;
   int           m_done_cyc = -1;
   logic         m_last_bit = 1'b0;
   int           cyc = 0;

   function automatic bit busy_at(input int k);
      return m_act && (k >= m_load_cyc) && (m_done_cyc < 0 || k <= m_done_cyc);
   endfunction

   always @(posedge SIM_CLK) begin
      bit   prev_busy;
      logic b;
      logic [W-1:0] word;
      cyc++;
      if (!SIM_RSTN) begin
         for (int i = 0; i < NR; i++) m_regs[i] = '0;
         bit_q.delete(); done_q.delete(); err_q.delete(); m_bits.delete();
         m_act = 1'b0; m_done_cyc = -1; m_last_bit = 1'b0;
      end else begin
         prev_busy = busy_at(cyc - 1);
         if (m_act && m_done_cyc >= 0 && cyc > m_done_cyc) m_act = 1'b0;
         if ((PHASE && WR_STB && int'(WR_SEL) >= NR) ||
             (PHASE && CLR_STB && int'(CLR_SEL) >= NR) ||
             (TLM_REQ && !prev_busy && int'(TLM_SEL) >= NR))
            err_q.push_back(cyc);
         for (int i = 0; i < NR; i++) begin
            if (PHASE && WR_STB && int'(WR_SEL) == i) m_regs[i] = WR_DATA;
            else if (PHASE && (CLR_ALL || (CLR_STB && int'(CLR_SEL) == i))) m_regs[i] = '0;
         end
         if (m_act && m_done_cyc < 0 && (cyc - 1) > m_load_cyc && BIT_STB && m_bits.size() > 0) begin
            b = m_bits.pop_front();
            bit_q.push_back('{cyc, b});
            m_last_bit = b;
            if (m_bits.size() == 0) begin
               m_done_cyc = cyc + 1;
               done_q.push_back(cyc + 1);
            end
         end
         if (TLM_REQ && !prev_busy && int'(TLM_SEL) < NR) begin
            word = m_regs[int'(TLM_SEL)];
            m_bits.delete();
            for (int j = W - 1; j >= 0; j--) m_bits.push_back(word[j]);
            if (PAR) m_bits.push_back(~(^word));
            m_act = 1'b1; m_load_cyc = cyc; m_done_cyc = -1;
         end
      end
   end

   // ---------------- monitor ----------------
   logic [NB-1:0] obs_word = '0;
   int            n_err_pulse = 0;

   always @(negedge SIM_CLK) begin
      logic [NR*W-1:0] exp_q;
      bit_ev_t ev;
      int st;
      if (!SIM_RSTN) begin
         chk("reset_outs", {REG_Q, TLM_BUSY, TLM_BIT, TLM_BIT_VLD, TLM_DONE, WR_ERR}, '0);
      end else begin
         for (int i = 0; i < NR; i++) exp_q[i*W +: W] = m_regs[i];
         chk("reg_q", REG_Q, exp_q);
         chk("busy", TLM_BUSY, busy_at(cyc));
         chk("tlm_bit_hold", TLM_BIT, m_last_bit);
         if (TLM_BIT_VLD) begin
            obs_word = {obs_word[NB-2:0], TLM_BIT};
            if (bit_q.size() == 0) chk("vld_unexpected", TLM_BIT_VLD, 0);
            else begin
               ev = bit_q.pop_front();
               chk("vld_cycle", cyc, ev.stamp);
               chk("bit_val", TLM_BIT, ev.b);
            end
         end else if (bit_q.size() > 0 && bit_q[0].stamp <= cyc) begin
            chk("vld_missing", TLM_BIT_VLD, 1);
            void'(bit_q.pop_front());
         end
         if (TLM_DONE) begin
            if (done_q.size() == 0) chk("done_unexpected", TLM_DONE, 0);
            else begin st = done_q.pop_front(); chk("done_cycle", cyc, st); end
         end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
            chk("done_missing", TLM_DONE, 1);
            void'(done_q.pop_front());
         end
         if (WR_ERR) begin
            n_err_pulse++;
            if (err_q.size() == 0) chk("err_unexpected", WR_ERR, 0);
            else begin st = err_q.pop_front(); chk("err_cycle", cyc, st); end
         end else if (err_q.size() > 0 && err_q[0] <= cyc) begin
            chk("err_missing", WR_ERR, 1);
            void'(err_q.pop_front());
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge SIM_CLK); #1;
   endtask

   task automatic clr_in();
      PHASE = 1'b0; WR_STB = 1'b0; CLR_STB = 1'b0; CLR_ALL = 1'b0;
      TLM_REQ = 1'b0; BIT_STB = 1'b0;
   endtask

   task automatic wr(input int sel, input logic [W-1:0] d);
      PHASE = 1'b1; WR_STB = 1'b1; WR_SEL = SW'(sel); WR_DATA = d;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300 && TLM_BUSY; i++) tick();
      chk("idle_timeout", TLM_BUSY, 0);
   endtask

   task automatic request(input int sel);
      TLM_REQ = 1'b1; TLM_SEL = SW'(sel); tick(); clr_in();
      tick();   // LOAD cycle: strobes here would be ignored
   endtask

   initial begin
      int e0;
      logic [NB-1:0] exp_c3, exp_01;
      exp_c3 = PAR ? NB'({8'hC3, 1'b1}) : NB'(8'hC3);
      exp_01 = PAR ? NB'({8'h01, 1'b0}) : NB'(8'h01);

      tick(); tick(); tick();
      SIM_RSTN = 1'b1;
      tick();

      wr(3, 8'hA5); tick(); clr_in();
      chk("tp_wr_slot3", REG_Q, 64'h0000_0000_A500_0000);

      WR_STB = 1'b1; WR_SEL = 3'd1; WR_DATA = 8'hFF; tick(); clr_in();
      chk("tp_nophase", REG_Q[15:8], 8'h00);
      wr(2, 8'h3C); CLR_STB = 1'b1; CLR_SEL = 3'd2; tick(); clr_in();
      chk("tp_wr_beats_clr", REG_Q[23:16], 8'h3C);

      // Snapshot isolation and busy-time request drop.
      wr(5, 8'hC3); tick(); clr_in();
      request(5);
      for (int n = 0; n < NB; n++) begin
         BIT_STB = 1'b1;
         if (n == 3) begin
            wr(5, 8'h00); TLM_REQ = 1'b1; TLM_SEL = 3'd5;
         end
         tick(); clr_in();
         tick(); tick(); tick();
      end
      wait_idle();
      chk("tp_c3_stream", obs_word, exp_c3);
      tick(); tick();

      // Out-of-range selects.
      e0 = n_err_pulse;
      wr(7, 8'h55); tick(); clr_in(); tick();
      TLM_REQ = 1'b1; TLM_SEL = 3'd6; tick(); clr_in();
      tick(); tick();
      chk("tp_err_pulses", n_err_pulse - e0, 2);
      chk("tp_err_no_busy", TLM_BUSY, 0);

      // Full transfer of 8'h01, then abort a second one after its 4th bit.
      wr(0, 8'h01); tick(); clr_in();
      request(0);
      for (int n = 0; n < NB; n++) begin
         BIT_STB = 1'b1; tick(); clr_in(); tick();
      end
      wait_idle();
      chk("tp_01_stream", obs_word, exp_01);
      request(0);
      for (int n = 0; n < 4; n++) begin
         BIT_STB = 1'b1; tick(); clr_in(); tick();
      end
      SIM_RSTN = 1'b0; tick(); tick();
      chk("tp_abort_regs", REG_Q, '0);
      SIM_RSTN = 1'b1; tick(); tick(); tick();
      chk("tp_abort_busy", TLM_BUSY, 0);

      // Randomised traffic.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 599) == 0) begin
            clr_in(); SIM_RSTN = 1'b0; tick(); tick(); SIM_RSTN = 1'b1;
         end
         PHASE   = ($urandom_range(0, 3) != 0);
         WR_STB  = ($urandom_range(0, 3) == 0);
         WR_SEL  = SW'($urandom_range(0, 7));
         WR_DATA = W'($urandom);
         CLR_STB = ($urandom_range(0, 7) == 0);
         CLR_SEL = SW'($urandom_range(0, 7));
         CLR_ALL = ($urandom_range(0, 63) == 0);
         TLM_REQ = ($urandom_range(0, 7) == 0);
         TLM_SEL = SW'($urandom_range(0, 7));
         BIT_STB = ($urandom_range(0, 2) == 0);
         tick();
      end
      clr_in();
      for (int i = 0; i < 300 && TLM_BUSY; i++) begin
         BIT_STB = ~BIT_STB; tick();
      end
      clr_in();
      wait_idle();
      tick(); tick(); tick();
      chk("end_bits_drained", bit_q.size(), 0);
      chk("end_done_drained", done_q.size(), 0);
      chk("end_err_drained", err_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
